// File: rtl/pc_trace_pkg.sv
// pc_trace_pkg: shared types and mode constants for the PC trace recorder.
// trace_entry_t is the default-width entry; the buffer builds its own per-instance copy.
package pc_trace_pkg;

  localparam int PC_W_DEF    = 64;
  localparam int INSTR_W_DEF = 32;

  // FILTER modes
  localparam int FILTER_ANY  = 0;
  localparam int FILTER_COND = 1;

  // WRAP modes
  localparam int WRAP_DROP      = 0;
  localparam int WRAP_OVERWRITE = 1;

  typedef struct packed {
    logic [PC_W_DEF-1:0]    pc;
    logic [INSTR_W_DEF-1:0] instr;
    logic                   kind;
  } trace_entry_t;

endpackage

// File: rtl/pc_trace_buffer_ram.sv
// trace_ram: DEPTH x W register array, one write port, one registered read port.
// Ports: i_we/i_waddr/i_wdata write; i_re/i_raddr read; o_rdata holds last read, 0 on reset.
module trace_ram
  import pc_trace_pkg::*;
#(
  parameter int W     = 97,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);

  logic [W-1:0] r_mem [DEPTH];
  logic [W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Read sees the pre-edge array, so a same-edge overwrite
  // of the slot being popped still returns the old entry.
  always_ff @(posedge clk) begin
    if (reset)     r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/pc_trace_buffer.sv
// pc_trace_buffer: circular trace of {PC, instr, kind} captured on PC-update strobes.
// In: Enable/PCOut/IMemOut/PCWrite/PCWriteCond capture, RdReq pop. Out: Rd*, Count/Empty/Full, OvfCount.
module pc_trace_buffer
  import pc_trace_pkg::*;
#(
  parameter int PC_W    = 64,
  parameter int INSTR_W = 32,
  parameter int DEPTH   = 16,
  parameter int FILTER  = 0,
  parameter int WRAP    = 1,
  parameter int OVF_W   = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       Enable,
  input  logic [PC_W-1:0]            PCOut,
  input  logic [INSTR_W-1:0]         IMemOut,
  input  logic                       PCWrite,
  input  logic                       PCWriteCond,
  input  logic                       RdReq,
  output logic                       RdValid,
  output logic [PC_W-1:0]            RdPC,
  output logic [INSTR_W-1:0]         RdInstr,
  output logic                       RdKind,
  output logic [$clog2(DEPTH+1)-1:0] Count,
  output logic                       Empty,
  output logic                       Full,
  output logic [OVF_W-1:0]           OvfCount
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [OVF_W-1:0] OVF_MAX = '1;
  localparam bit P_WRAP = (WRAP == WRAP_OVERWRITE);
  localparam bit P_COND = (FILTER == FILTER_COND);

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
    logic               kind;
  } entry_t;

  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [OVF_W-1:0] r_ovf;
  logic             r_rd_valid;

  logic   w_trig;
  logic   w_cap;
  logic   w_empty;
  logic   w_full;
  logic   w_pop;
  logic   w_ovf;
  logic   w_we;
  logic   w_rd_adv;
  entry_t w_wdata;
  entry_t w_rdata;

  assign w_trig  = P_COND ? PCWriteCond : (PCWrite | PCWriteCond);
  assign w_cap   = Enable & w_trig;
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == FULL_CNT);
  // Pop never bypasses a same-cycle write into an empty buffer.
  assign w_pop   = RdReq & ~w_empty;
  // Full with no pop to make room: overwrite or drop.
  assign w_ovf   = w_cap & w_full & ~w_pop;
  assign w_we    = w_cap & (~w_ovf | P_WRAP);
  // Overwriting the oldest slot drags the read pointer along.
  assign w_rd_adv = w_pop | (w_ovf & P_WRAP);

  assign w_wdata = '{pc: PCOut, instr: IMemOut, kind: PCWriteCond};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_ovf      <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_pop;
      if (w_we)     r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd_adv) r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_we && !w_rd_adv)     r_count <= r_count + CW'(1);
      else if (!w_we && w_pop)   r_count <= r_count - CW'(1);
      if (w_ovf && r_ovf != OVF_MAX) r_ovf <= r_ovf + OVF_W'(1);
    end
  end

  trace_ram #(
    .W     ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .i_we    (w_we),
    .i_waddr (r_wr_ptr),
    .i_wdata (w_wdata),
    .i_re    (w_pop),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );

  assign RdValid  = r_rd_valid;
  assign RdPC     = w_rdata.pc;
  assign RdInstr  = w_rdata.instr;
  assign RdKind   = w_rdata.kind;
  assign Count    = r_count;
  assign Empty    = w_empty;
  assign Full     = w_full;
  assign OvfCount = r_ovf;

endmodule

// File: tb/tb_pc_trace_buffer.sv
// tb_pc_trace_buffer: four configurations driven in lockstep, directed scenarios
// plus randomized traffic checked against a queue-based reference model.
module tb_pc_trace_buffer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic        pw = 1'b0;
  logic        pwc = 1'b0;
  logic        rdreq = 1'b0;
  logic [63:0] pc = '0;
  logic [31:0] im = '0;

  always #5 clk = ~clk;

  // 0: D16 any/wrap  1: D4 any/wrap  2: D4 any/drop ovf2b  3: D4 cond/wrap
  logic        o_v [4];
  logic [63:0] o_pc [4];
  logic [31:0] o_in [4];
  logic        o_k [4];
  logic        o_e [4];
  logic        o_f [4];
  logic [31:0] o_cnt [4];
  logic [31:0] o_ovf [4];

  logic [4:0]  cnt_a;
  logic [2:0]  cnt_b, cnt_c, cnt_d;
  logic [15:0] ovf_a, ovf_b, ovf_d;
  logic [1:0]  ovf_c;

  assign o_cnt[0] = 32'(cnt_a);
  assign o_cnt[1] = 32'(cnt_b);
  assign o_cnt[2] = 32'(cnt_c);
  assign o_cnt[3] = 32'(cnt_d);
  assign o_ovf[0] = 32'(ovf_a);
  assign o_ovf[1] = 32'(ovf_b);
  assign o_ovf[2] = 32'(ovf_c);
  assign o_ovf[3] = 32'(ovf_d);

  pc_trace_buffer #(.DEPTH(16), .FILTER(0), .WRAP(1)) u_a (
    .clk(clk), .reset(reset), .Enable(en), .PCOut(pc), .IMemOut(im),
    .PCWrite(pw), .PCWriteCond(pwc), .RdReq(rdreq),
    .RdValid(o_v[0]), .RdPC(o_pc[0]), .RdInstr(o_in[0]), .RdKind(o_k[0]),
    .Count(cnt_a), .Empty(o_e[0]), .Full(o_f[0]), .OvfCount(ovf_a));

  pc_trace_buffer #(.DEPTH(4), .FILTER(0), .WRAP(1)) u_b (
    .clk(clk), .reset(reset), .Enable(en), .PCOut(pc), .IMemOut(im),
    .PCWrite(pw), .PCWriteCond(pwc), .RdReq(rdreq),
    .RdValid(o_v[1]), .RdPC(o_pc[1]), .RdInstr(o_in[1]), .RdKind(o_k[1]),
    .Count(cnt_b), .Empty(o_e[1]), .Full(o_f[1]), .OvfCount(ovf_b));

  pc_trace_buffer #(.DEPTH(4), .FILTER(0), .WRAP(0), .OVF_W(2)) u_c (
    .clk(clk), .reset(reset), .Enable(en), .PCOut(pc), .IMemOut(im),
    .PCWrite(pw), .PCWriteCond(pwc), .RdReq(rdreq),
    .RdValid(o_v[2]), .RdPC(o_pc[2]), .RdInstr(o_in[2]), .RdKind(o_k[2]),
    .Count(cnt_c), .Empty(o_e[2]), .Full(o_f[2]), .OvfCount(ovf_c));

  pc_trace_buffer #(.DEPTH(4), .FILTER(1), .WRAP(1)) u_d (
    .clk(clk), .reset(reset), .Enable(en), .PCOut(pc), .IMemOut(im),
    .PCWrite(pw), .PCWriteCond(pwc), .RdReq(rdreq),
    .RdValid(o_v[3]), .RdPC(o_pc[3]), .RdInstr(o_in[3]), .RdKind(o_k[3]),
    .Count(cnt_d), .Empty(o_e[3]), .Full(o_f[3]), .OvfCount(ovf_d));

  int checks = 0;
  int failures = 0;

  // Reference model: a plain FIFO queue per configuration.
  int          dep  [4] = '{16, 4, 4, 4};
  bit          filt [4] = '{0, 0, 0, 1};
  bit          wrp  [4] = '{1, 1, 0, 1};
  int          omax [4] = '{65535, 65535, 3, 65535};
  logic [96:0] mq [4][$];
  logic        m_v [4];
  logic [96:0] m_d [4];
  int          m_ovf [4];

  task automatic model_update();
    for (int k = 0; k < 4; k++) begin
      bit cap;
      bit pop;
      logic [96:0] e;
      if (reset) begin
        mq[k].delete();
        m_v[k] = 1'b0;
        m_d[k] = '0;
        m_ovf[k] = 0;
      end else begin
        cap = en && (filt[k] ? pwc : (pw || pwc));
        pop = rdreq && (mq[k].size() > 0);
        m_v[k] = pop;
        if (pop) m_d[k] = mq[k].pop_front();
        if (cap) begin
          e = {pc, im, pwc};
          if (mq[k].size() < dep[k]) begin
            mq[k].push_back(e);
          end else begin
            if (m_ovf[k] < omax[k]) m_ovf[k]++;
            if (wrp[k]) begin
              void'(mq[k].pop_front());
              mq[k].push_back(e);
            end
          end
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic cyc(input bit w, input bit c, input logic [63:0] p,
                     input bit r);
    en = 1'b1; pw = w; pwc = c; pc = p; im = 32'h13; rdreq = r;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1; en = 1'b0; pw = 0; pwc = 0; rdreq = 0;
    step();
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({o_v[k], o_e[k], o_f[k], o_cnt[k], o_ovf[k], o_pc[k], o_in[k], o_k[k]}
          !== {1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 64'd0, 32'd0, 1'b0}) begin
        failures++;
        $display("FAIL reset[%0d] v=%0b e=%0b f=%0b cnt=%0d ovf=%0d pc=%h exp v=0 e=1 f=0 cnt=0 ovf=0 pc=0",
                 k, o_v[k], o_e[k], o_f[k], o_cnt[k], o_ovf[k], o_pc[k]);
      end
    end
  endtask

  task automatic test_basic();
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 64'(i * 4), 0);
      checks++;
      if (o_cnt[0] !== 32'(i + 1)) begin
        failures++;
        $display("FAIL basic_fill cnt=%0d exp=%0d", o_cnt[0], i + 1);
      end
    end
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 64'd0, 1);
      checks++;
      if ({o_v[0], o_pc[0], o_in[0], o_k[0], o_cnt[0]}
          !== {1'b1, 64'(i * 4), 32'h13, 1'b0, 32'(2 - i)}) begin
        failures++;
        $display("FAIL basic_pop%0d v=%0b pc=%h in=%h k=%0b cnt=%0d exp pc=%h cnt=%0d",
                 i, o_v[0], o_pc[0], o_in[0], o_k[0], o_cnt[0], i * 4, 2 - i);
      end
    end
    checks++;
    if (o_e[0] !== 1'b1) begin
      failures++;
      $display("FAIL basic_empty got=%0b exp=1", o_e[0]);
    end
    cyc(0, 0, 64'd0, 0);
    checks++;
    if (o_v[0] !== 1'b0) begin
      failures++;
      $display("FAIL basic_pulse v=%0b exp=0", o_v[0]);
    end
  endtask

  task automatic test_filter();
    cyc(1, 0, 64'h10, 0);
    cyc(0, 1, 64'h20, 0);
    checks++;
    if ({o_cnt[3], o_cnt[0]} !== {32'd1, 32'd2}) begin
      failures++;
      $display("FAIL filter_cnt d=%0d a=%0d exp d=1 a=2", o_cnt[3], o_cnt[0]);
    end
    cyc(0, 0, 64'd0, 1);
    checks++;
    if ({o_v[3], o_pc[3], o_k[3]} !== {1'b1, 64'h20, 1'b1}) begin
      failures++;
      $display("FAIL filter_pop v=%0b pc=%h k=%0b exp v=1 pc=20 k=1",
               o_v[3], o_pc[3], o_k[3]);
    end
    checks++;
    if ({o_pc[0], o_k[0]} !== {64'h10, 1'b0}) begin
      failures++;
      $display("FAIL filter_any pc=%h k=%0b exp pc=10 k=0", o_pc[0], o_k[0]);
    end
    cyc(0, 0, 64'd0, 1);
    cyc(0, 0, 64'd0, 1);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (o_e[k] !== 1'b1) begin
        failures++;
        $display("FAIL filter_drain[%0d] e=%0b exp=1", k, o_e[k]);
      end
    end
  endtask

  task automatic test_wrap();
    logic [63:0] exp_b;
    logic [63:0] exp_c;
    for (int i = 0; i < 6; i++) cyc(1, 0, 64'(i * 4), 0);
    checks++;
    if ({o_f[1], o_ovf[1], o_f[2], o_ovf[2]} !== {1'b1, 32'd2, 1'b1, 32'd2}) begin
      failures++;
      $display("FAIL wrap_full fb=%0b ob=%0d fc=%0b oc=%0d exp 1 2 1 2",
               o_f[1], o_ovf[1], o_f[2], o_ovf[2]);
    end
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 64'd0, 1);
      exp_b = 64'(8 + 4 * i);
      exp_c = 64'(4 * i);
      checks++;
      if ({o_v[1], o_pc[1], o_v[2], o_pc[2]} !== {1'b1, exp_b, 1'b1, exp_c}) begin
        failures++;
        $display("FAIL wrap_pop%0d b=%h c=%h exp b=%h c=%h",
                 i, o_pc[1], o_pc[2], exp_b, exp_c);
      end
    end
    cyc(0, 0, 64'd0, 1);
    cyc(0, 0, 64'd0, 1);
    checks++;
    if ({o_pc[0], o_e[0]} !== {64'h14, 1'b1}) begin
      failures++;
      $display("FAIL wrap_deep pc=%h e=%0b exp pc=14 e=1", o_pc[0], o_e[0]);
    end
  endtask

  task automatic test_full_cappop();
    logic [63:0] exp_pc;
    for (int i = 0; i < 4; i++) cyc(1, 0, 64'h100 + 64'(4 * i), 0);
    cyc(1, 0, 64'h200, 1);
    for (int k = 1; k < 3; k++) begin
      checks++;
      if ({o_v[k], o_pc[k], o_cnt[k], o_ovf[k]}
          !== {1'b1, 64'h100, 32'd4, 32'd2}) begin
        failures++;
        $display("FAIL cappop[%0d] v=%0b pc=%h cnt=%0d ovf=%0d exp 1 100 4 2",
                 k, o_v[k], o_pc[k], o_cnt[k], o_ovf[k]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 64'd0, 1);
      exp_pc = (i == 3) ? 64'h200 : 64'h104 + 64'(4 * i);
      checks++;
      if (o_pc[1] !== exp_pc) begin
        failures++;
        $display("FAIL cappop_drain%0d pc=%h exp=%h", i, o_pc[1], exp_pc);
      end
    end
    cyc(0, 0, 64'd0, 1);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({o_v[k], o_pc[k], o_e[k]} !== {1'b0, 64'h200, 1'b1}) begin
        failures++;
        $display("FAIL empty_rd[%0d] v=%0b pc=%h e=%0b exp v=0 pc=200 e=1",
                 k, o_v[k], o_pc[k], o_e[k]);
      end
    end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 7; i++) cyc(1, 0, 64'h300 + 64'(4 * i), 0);
    checks++;
    if ({o_ovf[2], o_ovf[1]} !== {32'd3, 32'd5}) begin
      failures++;
      $display("FAIL saturate c=%0d b=%0d exp c=3 b=5", o_ovf[2], o_ovf[1]);
    end
    for (int i = 0; i < 8; i++) cyc(0, 0, 64'd0, 1);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) cyc(1, 0, 64'h400 + 64'(4 * i), 0);
    reset = 1'b1; pw = 0; rdreq = 1'b1;
    step();
    reset = 1'b0; rdreq = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({o_cnt[k], o_e[k], o_v[k], o_ovf[k]} !== {32'd0, 1'b1, 1'b0, 32'd0}) begin
        failures++;
        $display("FAIL reset_mid[%0d] cnt=%0d e=%0b v=%0b ovf=%0d exp 0 1 0 0",
                 k, o_cnt[k], o_e[k], o_v[k], o_ovf[k]);
      end
    end
    step();
    checks++;
    if ({o_v[0], o_v[1], o_v[2], o_v[3]} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_mid_stale v=%b%b%b%b exp 0000",
               o_v[0], o_v[1], o_v[2], o_v[3]);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      reset = ($urandom_range(0, 99) == 0);
      en    = ($urandom_range(0, 7) != 0);
      pw    = 1'($urandom);
      pwc   = ($urandom_range(0, 2) == 0);
      pc    = {$urandom(), $urandom()};
      im    = $urandom();
      rdreq = ($urandom_range(0, 4) < 2);
      step();
      for (int k = 0; k < 4; k++) begin
        checks++;
        if ({o_v[k], o_pc[k], o_in[k], o_k[k], o_cnt[k], o_e[k], o_f[k], o_ovf[k]}
            !== {m_v[k], m_d[k], 32'(mq[k].size()), mq[k].size() == 0,
                 mq[k].size() == dep[k], 32'(m_ovf[k])}) begin
          failures++;
          $display("FAIL rand[%0d] n=%0d v=%0b pc=%h in=%h k=%0b cnt=%0d ovf=%0d exp v=%0b pc=%h in=%h k=%0b cnt=%0d ovf=%0d",
                   k, n, o_v[k], o_pc[k], o_in[k], o_k[k], o_cnt[k], o_ovf[k],
                   m_v[k], m_d[k][96:33], m_d[k][32:1], m_d[k][0],
                   mq[k].size(), m_ovf[k]);
        end
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_filter();
    test_wrap();
    test_full_cappop();
    test_saturate();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
